// File: rtl/qm_pkg.sv
// qm_pkg: shared states, defaults and width helper for the minterm extractor
package qm_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DRAIN} state_t;
  localparam int N_IN_DEF = 13;
  localparam int LAT_DEF = 0;
  localparam int DEPTH_DEF = 4;
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/minterm_fifo.sv
// minterm_fifo: synchronous FIFO with occupancy count, head visible on dout
module minterm_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
    end
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/minterm_extractor.sv
// minterm_extractor: sweeps all input vectors of a circuit and streams ON-set
// minterm indices in ascending order over valid/ready
module minterm_extractor import qm_pkg::*; #(
  parameter int N_IN = N_IN_DEF,
  parameter int LAT = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic [N_IN-1:0]          vec_o,
  input  logic                     f_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [N_IN-1:0]          m_index_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [cnt_w(N_IN)-1:0]   count_o
);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH + LAT + 2) + 1;
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
  state_t state, nxt;
  logic [N_IN:0] cnt;
  logic [LAT:0] pv;
  logic [N_IN-1:0] pidx [LAT+1];
  logic [N_IN-1:0] idx;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] inflight;
  logic full, empty, push, pop, issue, credit_ok;
  assign vec_o = pidx[0];
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) inflight = inflight + CW'(pv[k]);
  end
  // pre-pop occupancy is counted on purpose: conservative but never overflows
  assign credit_ok = !full && (CW'(fcnt) + inflight < CW'(DEPTH));
  assign issue = (state == IDLE && start_i) || (state == SWEEP && credit_ok);
  assign idx = state == IDLE ? '0 : cnt[N_IN-1:0];
  assign push = pv[LAT] && f_i;
  assign pop = m_valid_o && m_ready_i;
  assign m_valid_o = !empty;
  assign busy_o = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start_i ? SWEEP : IDLE;
      SWEEP: nxt = issue && cnt == LAST ? FLUSH : SWEEP;
      FLUSH: nxt = inflight == '0 ? DRAIN : FLUSH;
      DRAIN: nxt = empty ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pv <= '0;
      for (int k = 0; k <= LAT; k++) pidx[k] <= '0;
      count_o <= '0;
      done_o <= 1'b0;
    end else begin
      state <= nxt;
      done_o <= state == DRAIN && empty;
      pv[0] <= issue;
      for (int k = 1; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pidx[k] <= pidx[k-1];
      end
      if (issue) begin
        pidx[0] <= idx;
        cnt <= {1'b0, idx} + 1'b1;
      end
      if (state == IDLE && start_i) count_o <= '0;
      else if (push) count_o <= count_o + 1'b1;
    end
  minterm_fifo #(.W(N_IN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pidx[LAT]),
    .dout(m_index_o), .count(fcnt), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_minterm_extractor.sv
// tb_minterm_extractor: random and directed sweeps checked against a truth-table model
module tb_minterm_extractor;
  localparam int N = 5, L = 2, D = 4, V = 1 << N;
  logic clk = 0, rst = 1, start_i = 0, m_ready_i = 1, f_i;
  logic [N-1:0] vec_o, m_index_o;
  logic m_valid_o, busy_o, done_o;
  logic [N:0] count_o;
  int checks = 0, errors = 0;
  logic tt [V];
  logic [N-1:0] vh [L] = '{default: '0};
  int exp_q[$];
  int rx = 0, last_rx = -1, done_cnt = 0, c;
  bit saw_valid = 0;
  logic pv_ = 0, pr_ = 0;
  logic [N-1:0] pi_ = '0;

  always #5 clk = ~clk;

  minterm_extractor #(.N_IN(N), .LAT(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vec_o(vec_o), .f_i(f_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_index_o(m_index_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  // circuit under evaluation: truth table seen through an L-cycle delay
  always @(posedge clk) begin
    vh[1] <= vh[0];
    vh[0] <= vec_o;
  end
  assign f_i = tt[vh[L-1]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pv_ = 0;
    else begin
      if (pv_ && !pr_) begin
        chk("hold_valid", 32'(m_valid_o), 1);
        chk("hold_index", 32'(m_index_o), 32'(pi_));
      end
      if (m_valid_o) saw_valid = 1;
      if (done_o) done_cnt++;
      if (m_valid_o && m_ready_i) begin
        if (rx < exp_q.size()) chk("minterm", 32'(m_index_o), exp_q[rx]);
        else chk("extra_minterm", rx, exp_q.size());
        last_rx = int'(m_index_o);
        rx++;
      end
      pv_ = m_valid_o;
      pr_ = m_ready_i;
      pi_ = m_index_o;
    end
  end

  task automatic load_model();
    exp_q.delete();
    for (int i = 0; i < V; i++) if (tt[i]) exp_q.push_back(i);
    rx = 0;
    saw_valid = 0;
  endtask

  task automatic begin_sweep();
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0;
    chk("busy_rise", 32'(busy_o), 1);
    chk("first_vec", 32'(vec_o), 0);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for 20 cycles then high
  task automatic run(input int rmode, input bit inj, output int cyc);
    int busy_c = 0;
    load_model();
    m_ready_i = rmode != 2;
    begin_sweep();
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_o) busy_c++;
      if (rmode == 2 && cyc == 20) begin
        chk("stall_vec", 32'(vec_o), 3);
        chk("stall_valid", 32'(m_valid_o), 1);
        chk("stall_head", 32'(m_index_o), 0);
        chk("stall_count", 32'(count_o), 4);
      end
      m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : cyc >= 20;
      start_i = inj && cyc == 10;
    end
    start_i = 0;
    chk("done_seen", 32'(done_o), 1);
    chk("busy_span", busy_c, cyc - 1);
    chk("count", 32'(count_o), exp_q.size());
    chk("received", rx, exp_q.size());
    @(posedge clk); #1;
    chk("done_pulse", 32'(done_o), 0);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, "_vec"}, 32'(vec_o), 0);
    chk({nm, "_valid"}, 32'(m_valid_o), 0);
    chk({nm, "_index"}, 32'(m_index_o), 0);
    chk({nm, "_busy"}, 32'(busy_o), 0);
    chk({nm, "_done"}, 32'(done_o), 0);
    chk({nm, "_count"}, 32'(count_o), 0);
  endtask

  task automatic abort_test();
    int w = 0, d;
    for (int i = 0; i < V; i++) tt[i] = 1'($urandom_range(0, 1));
    tt[1] = 1;
    load_model();
    m_ready_i = 1;
    begin_sweep();
    while (vec_o !== 5 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_5", 32'(vec_o), 5);
    d = done_cnt;
    rst = 1;
    #1 reset_values("abort");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("no_done_after_abort", done_cnt, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_values("reset");
    rst = 0;
    for (int i = 0; i < V; i++) tt[i] = i == V - 1;
    run(0, 0, c);
    chk("and_latency", c, V + L + 2);
    chk("and_index", last_rx, V - 1);
    chk("and_count", 32'(count_o), 1);
    for (int i = 0; i < V; i++) tt[i] = 0;
    run(0, 0, c);
    chk("zero_valid", 32'(saw_valid), 0);
    chk("zero_latency", c, V + L + 2);
    for (int i = 0; i < V; i++) tt[i] = 1;
    run(2, 0, c);
    chk("ones_count", 32'(count_o), V);
    for (int i = 0; i < V; i++) begin
      logic [N-1:0] b;
      b = N'(i);
      tt[i] = ^b;
    end
    run(1, 0, c);
    chk("parity_count", 32'(count_o), V / 2);
    for (int i = 0; i < V; i++) tt[i] = 1'($urandom_range(0, 1));
    run(1, 1, c);
    abort_test();
    run(1, 0, c);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
